// File: rtl/fitness_pkg.sv
// Shared types and sizing helpers for the fitness scorer and its bus interface.
package fitness_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int N_IN_DEF  = 4;
  localparam int N_OUT_DEF = 4;
  localparam int NUM_VEC   = 2**N_IN_DEF;
  localparam int TT_W      = N_OUT_DEF * NUM_VEC;

  // Widths sized to hold the full inclusive range 0..max.
  function automatic int score_w(input int tt_w);
    return $clog2(tt_w + 1);
  endfunction

  function automatic int row_w(input int num_vec);
    return $clog2(num_vec + 1);
  endfunction

endpackage

// File: rtl/fitness_scorer_if.sv
// Evaluation bus between the evolution controller/candidate (master) and the scorer (slave).
interface fitness_scorer_if
  import fitness_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4
) ();

  logic                                  start;
  logic [N_OUT*(2**N_IN)-1:0]            target;
  logic [N_OUT-1:0]                      dut_out;
  logic [N_IN-1:0]                       dut_in;
  logic                                  busy;
  logic                                  done;
  logic [score_w(N_OUT*(2**N_IN))-1:0]   score;
  logic [row_w(2**N_IN)-1:0]             rows_correct;
  logic                                  perfect;
  logic [N_OUT-1:0]                      out_err;

  modport master (
    output start, target, dut_out,
    input  dut_in, busy, done, score, rows_correct, perfect, out_err
  );

  modport slave (
    input  start, target, dut_out,
    output dut_in, busy, done, score, rows_correct, perfect, out_err
  );

endinterface

// File: rtl/fitness_scorer_bit_match_count.sv
// Compares one candidate output word with its expected slice: match popcount,
// all-match flag and per-bit mismatch vector.
module bit_match_count #(
  parameter int N_OUT = 4,
  parameter int CW    = $clog2(N_OUT + 1)
) (
  input  logic [N_OUT-1:0] i_dut_out,
  input  logic [N_OUT-1:0] i_expected,
  output logic [CW-1:0]    o_count,
  output logic             o_all_match,
  output logic [N_OUT-1:0] o_mismatch
);

  logic [N_OUT-1:0] w_match;

  assign o_mismatch  = i_dut_out ^ i_expected;
  assign w_match     = ~o_mismatch;
  assign o_all_match = &w_match;

  always_comb begin
    o_count = '0;
    for (int k = 0; k < N_OUT; k++) begin
      o_count = o_count + CW'(w_match[k]);
    end
  end

endmodule

// File: rtl/fitness_scorer.sv
// Sweeps every input vector through a combinational candidate, samples after a
// settle window and scores the outputs against a latched truth table.
module fitness_scorer
  import fitness_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int N_OUT         = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input logic             clk,
  input logic             reset_n,
  fitness_scorer_if.slave bus
);

  localparam int NV = 2**N_IN;
  localparam int TW = N_OUT * NV;
  localparam int SW = score_w(TW);
  localparam int RW = row_w(NV);
  localparam int CW = $clog2(N_OUT + 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("fitness_scorer: SETTLE_CYCLES must be 1..255");
  end

  state_t           r_state, w_state_next;
  logic [N_IN-1:0]  r_vec, w_vec_next;
  logic [7:0]       r_cnt, w_cnt_next;
  logic [TW-1:0]    r_target, w_target_next;
  logic [SW-1:0]    r_score, w_score_next;
  logic [RW-1:0]    r_rows, w_rows_next;
  logic [N_OUT-1:0] r_err, w_err_next;

  logic [N_OUT-1:0] w_expected;
  logic [N_OUT-1:0] w_mismatch;
  logic [CW-1:0]    w_match_cnt;
  logic             w_all_match;
  logic             w_sample;

  assign w_expected = r_target[int'(r_vec)*N_OUT +: N_OUT];
  assign w_sample   = (r_cnt == 8'(SETTLE_CYCLES - 1));

  bit_match_count #(.N_OUT(N_OUT), .CW(CW)) u_match (
    .i_dut_out   (bus.dut_out),
    .i_expected  (w_expected),
    .o_count     (w_match_cnt),
    .o_all_match (w_all_match),
    .o_mismatch  (w_mismatch)
  );

  always_comb begin
    w_state_next  = r_state;
    w_vec_next    = r_vec;
    w_cnt_next    = r_cnt;
    w_target_next = r_target;
    w_score_next  = r_score;
    w_rows_next   = r_rows;
    w_err_next    = r_err;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_target_next = bus.target;
          w_score_next  = '0;
          w_rows_next   = '0;
          w_err_next    = '0;
          w_vec_next    = '0;
          w_cnt_next    = '0;
          w_state_next  = RUN;
        end
      end
      RUN: begin
        // Sample on the last cycle of the settle window for the current vector.
        if (w_sample) begin
          w_score_next = r_score + SW'(w_match_cnt);
          w_rows_next  = r_rows + RW'(w_all_match);
          w_err_next   = r_err | w_mismatch;
          w_cnt_next   = '0;
          if (&r_vec) begin
            w_state_next = DONE;
          end else begin
            w_vec_next = r_vec + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_vec    <= '0;
      r_cnt    <= '0;
      r_target <= '0;
      r_score  <= '0;
      r_rows   <= '0;
      r_err    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_vec    <= w_vec_next;
      r_cnt    <= w_cnt_next;
      r_target <= w_target_next;
      r_score  <= w_score_next;
      r_rows   <= w_rows_next;
      r_err    <= w_err_next;
    end
  end

  assign bus.dut_in       = (r_state == RUN) ? r_vec : '0;
  assign bus.busy         = (r_state == RUN);
  assign bus.done         = (r_state == DONE);
  assign bus.score        = r_score;
  assign bus.rows_correct = r_rows;
  assign bus.out_err      = r_err;
  assign bus.perfect      = (r_score == SW'(TW));

endmodule

// File: tb/tb_fitness_scorer.sv
// Directed bench for fitness_scorer: loopback, stuck-at, single fault, settle
// boundary and start/reset/target hazards, each with hand-computed results.
`timescale 1ns/1ps
module tb_fitness_scorer;
  import fitness_pkg::*;

  localparam int S = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fitness_scorer_if #(.N_IN(4), .N_OUT(4)) bus ();

  fitness_scorer #(.N_IN(4), .N_OUT(4), .SETTLE_CYCLES(S)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Candidate model: 0 = loopback, 1 = stuck at zero, 2 = loopback delayed by 'delay' registers
  int         mode  = 0;
  int         delay = 1;
  logic [3:0] d_pipe [4];

  always @(posedge clk) begin
    d_pipe[0] <= bus.dut_in;
    for (int i = 1; i < 4; i++) d_pipe[i] <= d_pipe[i-1];
  end

  always_comb begin
    bus.dut_out = '0;
    case (mode)
      0:       bus.dut_out = bus.dut_in;
      1:       bus.dut_out = '0;
      2:       bus.dut_out = d_pipe[delay-1];
      default: bus.dut_out = '0;
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ident();
    logic [63:0] t;
    t = '0;
    for (int v = 0; v < 16; v++) t[v*4 +: 4] = 4'(v);
    return t;
  endfunction

  // Launch one evaluation; optional hazards are applied n cycles after the accept edge.
  task automatic run_eval(input string name, input int hz_start, input int hz_reset,
                          input int hz_tgt, output int lat);
    lat = -1;
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({name, "_busy_at_accept"}, bus.busy, 1);
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        break;
      end
      if (n == hz_start)     bus.start = 1'b1;
      if (n == hz_start + 1) bus.start = 1'b0;
      if (n == hz_tgt)       bus.target = ~bus.target;
      if (n == hz_reset)     reset_n = 1'b0;
      if (n == hz_reset + 1) begin
        check({name, "_rst_busy"},   bus.busy,   0);
        check({name, "_rst_dut_in"}, bus.dut_in, 0);
        check({name, "_rst_score"},  bus.score,  0);
        reset_n = 1'b1;
      end
    end
    if (lat > 0) begin
      @(posedge clk);
      #1;
      check({name, "_done_single"}, bus.done, 0);
      check({name, "_idle_after"},  bus.busy, 0);
    end
    $display("run %s: lat=%0d score=%0d rows=%0d perfect=%0d out_err=%h",
             name, lat, bus.score, bus.rows_correct, bus.perfect, bus.out_err);
  endtask

  int lat;

  initial begin
    bus.start  = 1'b0;
    bus.target = '0;
    reset_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dut_in",  bus.dut_in,       0);
    check("rst_busy",    bus.busy,         0);
    check("rst_done",    bus.done,         0);
    check("rst_score",   bus.score,        0);
    check("rst_rows",    bus.rows_correct, 0);
    check("rst_perfect", bus.perfect,      0);
    check("rst_out_err", bus.out_err,      0);
    reset_n = 1'b1;

    // Loopback with identity table
    mode = 0;
    bus.target = ident();
    run_eval("loopback", -10, -10, -10, lat);
    check("loop_latency", lat, 64);
    check("loop_score",   bus.score, 64);
    check("loop_rows",    bus.rows_correct, 16);
    check("loop_perfect", bus.perfect, 1);
    check("loop_out_err", bus.out_err, 0);
    repeat (3) @(posedge clk);
    #1;
    check("loop_hold_score", bus.score, 64);

    // Stuck-at-zero candidate against all-ones table
    mode = 1;
    bus.target = '1;
    run_eval("stuck0", -10, -10, -10, lat);
    check("stuck_latency", lat, 64);
    check("stuck_score",   bus.score, 0);
    check("stuck_rows",    bus.rows_correct, 0);
    check("stuck_out_err", bus.out_err, 4'hF);
    check("stuck_perfect", bus.perfect, 0);

    // Single flipped truth-table bit: vector 7, output 2
    mode = 0;
    bus.target = ident() ^ (64'd1 << 30);
    run_eval("single_fault", -10, -10, -10, lat);
    check("fault_score",   bus.score, 63);
    check("fault_rows",    bus.rows_correct, 15);
    check("fault_out_err", bus.out_err, 4'b0100);
    check("fault_perfect", bus.perfect, 0);

    // Settle boundary: S-1 register delay still settles in time
    mode  = 2;
    delay = S - 1;
    bus.target = ident();
    run_eval("delay_s_minus_1", -10, -10, -10, lat);
    check("dly3_score", bus.score, 64);

    // Delay of S: each vector samples the previous one (v=0 sees 0), 26 bits differ
    delay = S;
    run_eval("delay_s", -10, -10, -10, lat);
    check("dly4_below_64", bus.score < 64, 1);
    check("dly4_score",    bus.score, 38);
    check("dly4_rows",     bus.rows_correct, 1);
    check("dly4_out_err",  bus.out_err, 4'hF);

    // Start at vector 5 ignored; target change mid-run ignored
    mode = 0;
    bus.target = ident();
    run_eval("start_hazard", 21, -10, 10, lat);
    check("shz_latency", lat, 64);
    check("shz_score",   bus.score, 64);
    check("shz_rows",    bus.rows_correct, 16);

    // Reset during vector 7: abort with no done pulse
    bus.target = ident();
    run_eval("reset_hazard", -10, 29, -10, lat);
    check("rhz_no_done", lat, -1);
    check("rhz_score",   bus.score, 0);
    check("rhz_rows",    bus.rows_correct, 0);
    check("rhz_out_err", bus.out_err, 0);
    check("rhz_dut_in",  bus.dut_in, 0);

    // Clean run afterwards
    run_eval("after_reset", -10, -10, -10, lat);
    check("rerun_latency", lat, 64);
    check("rerun_score",   bus.score, 64);
    check("rerun_perfect", bus.perfect, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
